// File: rtl/bram_port_arbiter.sv
// Two-master valid/ready arbiter sharing one block-RAM port, with a per-owner
// burst counter bounding how long the non-owner can be kept waiting.
module bram_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    m0_valid,
   output logic                    m0_ready,
   input  logic                    m0_we,
   input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   output logic                    m0_rvalid,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   input  logic                    m1_valid,
   output logic                    m1_ready,
   input  logic                    m1_we,
   input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   output logic                    m1_rvalid,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic                    bram_en,
   output logic                    bram_we,
   output logic [DATA_WIDTH/8-1:0] bram_wstrb,
   output logic [ADDR_WIDTH-1:0]   bram_addr,
   output logic [DATA_WIDTH-1:0]   bram_din,
   input  logic [DATA_WIDTH-1:0]   bram_dout
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             m0_rvalid_q, m1_rvalid_q;
   logic             owner_valid, loser_valid;
   logic             grant, win_id, sel1;

   always_comb begin
      owner_valid = owner_q ? m1_valid : m0_valid;
      loser_valid = owner_q ? m0_valid : m1_valid;
      grant       = 1'b0;
      win_id      = owner_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;

      // Owner keeps the port unless the waiting master has hit the burst limit.
      if (owner_valid && !(loser_valid && (cnt_q == CNT_MAX))) begin
         grant  = 1'b1;
         win_id = owner_q;
      end else if (loser_valid) begin
         grant  = 1'b1;
         win_id = ~owner_q;
      end

      if (grant) begin
         if (win_id == owner_q) begin
            cnt_d = loser_valid ? (cnt_q + CNT_ONE) : '0;
         end else begin
            owner_d = win_id;
            cnt_d   = owner_valid ? CNT_ONE : '0;
         end
      end
   end

   assign sel1       = grant & win_id;
   assign m0_ready   = grant & ~win_id;
   assign m1_ready   = grant & win_id;
   assign bram_en    = grant;
   assign bram_we    = grant & (sel1 ? m1_we : m0_we);
   assign bram_wstrb = sel1 ? m1_wstrb : m0_wstrb;
   assign bram_addr  = sel1 ? m1_addr  : m0_addr;
   assign bram_din   = sel1 ? m1_wdata : m0_wdata;

   assign m0_rvalid  = m0_rvalid_q;
   assign m1_rvalid  = m1_rvalid_q;
   assign m0_rdata   = bram_dout;
   assign m1_rdata   = bram_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q     <= 1'b0;
         cnt_q       <= '0;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         m0_rvalid_q <= m0_ready;
         m1_rvalid_q <= m1_ready;
      end
   end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Two-requester arbiter that shares one port of the dual-port block RAM between two masters. Typical pairing is the core data bus (m0) and the program loader/debug bus (m1). Each request is a valid/ready transfer. The arbiter drives the RAM port and returns each response one cycle after acceptance. A per-owner burst counter gives bounded-latency fairness.

Parameters:
ADDR_WIDTH, 10, word-address width of the RAM port.
DATA_WIDTH, 32, data width; must be a multiple of 8.
MAX_BURST, 4, maximum consecutive accepts by the current owner while the other master waits; must be at least 1 (1 = strict round-robin).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
m0_valid  in  1  master 0 request valid.
m0_ready  out  1  master 0 request accepted this cycle.
m0_we  in  1  master 0 write enable.
m0_wstrb  in  DATA_WIDTH/8  master 0 byte strobes.
m0_addr  in  ADDR_WIDTH  master 0 word address.
m0_wdata  in  DATA_WIDTH  master 0 write data.
m0_rvalid  out  1  master 0 response pulse.
m0_rdata  out  DATA_WIDTH  master 0 response data.
m1_*  (same set as m0_*)  master 1 request/response.
bram_en  out  1  RAM port enable.
bram_we  out  1  RAM port write enable.
bram_wstrb  out  DATA_WIDTH/8  RAM byte strobes.
bram_addr  out  ADDR_WIDTH  RAM address.
bram_din  out  DATA_WIDTH  RAM write data.
bram_dout  in  DATA_WIDTH  RAM read data, registered inside the RAM, 1-cycle latency.

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous and active-low.
- Reset values: owner=0, cnt=0, m0_rvalid=0, m1_rvalid=0.
- Combinational outputs: m*_ready and all bram_* outputs are combinational from the valids, owner and cnt. The cnt register is $clog2(MAX_BURST+1) bits wide.
- Loser: the master that is not the owner.
- Winner selection, evaluated each cycle:
  - Winner = owner if owner is valid AND NOT (loser valid AND cnt==MAX_BURST).
  - Otherwise winner = loser if loser is valid.
  - Otherwise there is no winner.
- Ready and accept: m*_ready=1 only for the winner. Ready never asserts without the matching valid. Accept = winner's valid & ready. At most one accept per cycle.
- RAM drive: bram_en=1 exactly on accept cycles. On those cycles bram_we/wstrb/addr/din mirror the winner's inputs. When idle, bram_en=0 and bram_we=0; the other bram_* outputs are don't-care (implemented as the m0 inputs).
- Owner/counter update, only on accept cycles (idle cycles hold both):
  - Winner==owner: cnt <= (loser valid) ? cnt+1 : 0.
  - Winner!=owner: owner <= winner; cnt <= (new loser valid) ? 1 : 0.
  - Result: while both masters stream continuously, grants alternate in runs of exactly MAX_BURST.
- Response:
  - The cycle after an accept, m<winner>_rvalid=1 for exactly one cycle. It is registered with the winner id.
  - m*_rdata is a combinational pass-through of bram_dout and is valid only while the matching rvalid is 1.
  - Writes also produce an rvalid. Their rdata is the pre-write word (the RAM is read-first).
  - There is no response backpressure; masters must sink rvalid.
- Throughput: back-to-back accepts every cycle are allowed. Responses pipeline behind accepts at one per cycle.
- Handshake rules for masters: a master holds addr/we/wstrb/wdata stable while valid is high and not ready. The arbiter does not check this.
- Boundaries:
  - wstrb=0 with we=1 is still accepted, leaves memory unchanged, and returns rvalid.
  - Address wrap is not applicable; addresses pass straight through.
- Reset mid-operation: rvalid clears immediately, and any outstanding response is dropped. owner=0 and cnt=0. The RAM contents are unaffected.

Test Plan:
- Single read: m0 reads addr 5, which was preloaded with 0xDEADBEEF, m1 idle -> m0_ready=1 in the same cycle, bram_en=1, bram_addr=5; next cycle m0_rvalid=1 with m0_rdata=0xDEADBEEF, m1_rvalid=0.
- Strobed write then read: m1 writes addr 3, wdata 0x11223344, wstrb 4'b0011, old value 0xAABBCCDD -> the write response returns 0xAABBCCDD; a subsequent read of addr 3 returns 0xAABB3344.
- Contention, MAX_BURST=4: both masters hold valid continuously for 16 cycles from reset -> grant sequence m0×4, m1×4, m0×4, m1×4; rvalid follows the same sequence delayed by 1 cycle.
- Contention, MAX_BURST=1: both masters valid -> grants strictly alternate m0, m1, m0, ...; if m1 drops valid, m0 is granted every cycle and cnt returns to 0.
- Idle and owner hand-off: only m1 requests (owner switches to 1), then both request -> m1 keeps priority until cnt reaches MAX_BURST; on fully idle cycles bram_en=0 and owner/cnt hold.
- Reset mid-operation: assert rst_n=0 in the cycle after an m0 accept -> m0_rvalid is 0 during and after reset with no late pulse; after release, a m1-only request is granted immediately.
